// File: rtl/qnigma_alu_io.sv
// qnigma_alu_io
// Streaming load/unload front-end for the multi-limb ALU core.
// Operands A and B arrive as L-bit words (least-significant first) and are
// assembled into WA-bit operand registers. A one-cycle calculate strobe is
// then issued to the core. The block waits for the core's done pulse,
// captures the result and overflow flag, and streams the result back out as
// L-bit words under valid/ready flow control.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_dat/in_val/in_rdy     operand word stream (A words, then B words)
//   in_op                    operation, sampled with the first A word
//                            (01 add, 10 sub, 11 mul, 00 illegal)
//   err                      one-cycle pulse when an illegal op word is dropped
//   busy                     transaction in progress
//   alu_opa/alu_opb          operands to the core
//   alu_mul/alu_add/alu_sub  core operation select
//   alu_cal                  one-cycle calculate strobe
//   alu_res/alu_ovf/alu_don  core result, overflow flag, done pulse
//   out_dat/out_val/out_rdy  result word stream
//   out_lst                  marks the last result word
//   out_ovf                  captured overflow flag

module qnigma_alu_io #(
    parameter int N  = 16,
    parameter int K  = 16,
    parameter int WA = N * K,
    parameter int L  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [L-1:0]       in_dat,
    input  logic               in_val,
    output logic               in_rdy,
    input  logic [1:0]         in_op,
    output logic               err,
    output logic               busy,
    output logic [WA-1:0]      alu_opa,
    output logic [WA-1:0]      alu_opb,
    output logic               alu_mul,
    output logic               alu_add,
    output logic               alu_sub,
    output logic               alu_cal,
    input  logic [2*N*K-1:0]   alu_res,
    input  logic               alu_ovf,
    input  logic               alu_don,
    output logic [L-1:0]       out_dat,
    output logic               out_val,
    input  logic               out_rdy,
    output logic               out_lst,
    output logic               out_ovf
);

    localparam int RW = 2 * N * K;
    localparam int NA = WA / L;
    localparam int CW = $clog2(RW / L + 1);

    typedef enum logic [2:0] {
        LDA,
        LDB,
        CAL,
        WAIT,
        OUT
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] ctr;
    logic [1:0]    op;
    logic [RW-1:0] res;
    logic          in_fire;
    logic          out_fire;
    logic          illegal;
    logic [CW-1:0] last_ld;
    logic [CW-1:0] last_out;

    assign in_fire  = in_val & in_rdy;
    assign out_fire = out_val & out_rdy;
    // Only the first A word carries the op; an illegal op there drops the word.
    assign illegal  = (state == LDA) && (ctr == '0) && (in_op == 2'b00);
    assign last_ld  = CW'(NA - 1);
    // Multiply returns a double-width result; add/sub only the low WA bits.
    assign last_out = (op == 2'b11) ? CW'(2 * NA - 1) : CW'(NA - 1);

    assign alu_add  = (op == 2'b01);
    assign alu_sub  = (op == 2'b10);
    assign alu_mul  = (op == 2'b11);

    always_ff @(posedge clk) begin
        if (rst) state <= LDA;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_rdy    = 1'b0;
        alu_cal   = 1'b0;
        out_val   = 1'b0;
        out_lst   = 1'b0;
        out_dat   = '0;
        case (state)
            LDA: begin
                in_rdy = 1'b1;
                if (in_fire && !illegal && ctr == last_ld) state_nxt = LDB;
            end
            LDB: begin
                in_rdy = 1'b1;
                if (in_fire && ctr == last_ld) state_nxt = CAL;
            end
            CAL: begin
                alu_cal   = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (alu_don) state_nxt = OUT;
            end
            OUT: begin
                out_val = 1'b1;
                out_lst = (ctr == last_out);
                out_dat = res[int'(ctr) * L +: L];
                if (out_fire && out_lst) state_nxt = LDA;
            end
            default: state_nxt = LDA;
        endcase
    end

    // Datapath: ctr indexes the operand word being loaded or the result
    // word being emitted; it wraps to zero at every phase boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctr     <= '0;
            op      <= 2'b00;
            alu_opa <= '0;
            alu_opb <= '0;
            res     <= '0;
            out_ovf <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                LDA: begin
                    if (in_fire) begin
                        if (illegal) begin
                            err <= 1'b1;
                        end else begin
                            alu_opa[int'(ctr) * L +: L] <= in_dat;
                            if (ctr == '0) begin
                                op   <= in_op;
                                busy <= 1'b1;
                            end
                            ctr <= (ctr == last_ld) ? '0 : ctr + 1'b1;
                        end
                    end
                end
                LDB: begin
                    if (in_fire) begin
                        alu_opb[int'(ctr) * L +: L] <= in_dat;
                        ctr <= (ctr == last_ld) ? '0 : ctr + 1'b1;
                    end
                end
                WAIT: begin
                    if (alu_don) begin
                        res     <= alu_res;
                        out_ovf <= alu_ovf;
                        ctr     <= '0;
                    end
                end
                OUT: begin
                    if (out_fire) begin
                        if (out_lst) begin
                            ctr  <= '0;
                            busy <= 1'b0;
                        end else begin
                            ctr <= ctr + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
